m_stage_mem_ctrl: RTL and testbench

Memory-stage consumer of the EX/M pipeline register outputs. It turns M-stage load/store controls into a req/ready handshake with the data cache and formats halfword loads and stores. It produces the M/WB register contents and the stall that drives the EX/M write enable (EX_MWrite = ~M_stall). The cache can take any number of cycles to respond.

---
 rtl/m_stage_mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_m_stage_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage_mem_ctrl.sv
// Memory-stage controller: turns M-stage load/store controls into a cache req/ready handshake and builds the M/WB register.
// Optional MEM_CTRL_PERF_EN adds perf_access / perf_wait counters.
module m_stage_mem_ctrl #(
  parameter int data_size = 32,
  parameter int pc_size   = 18,
  parameter int addr_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemtoReg,
  input  logic                 M_RegWrite,
  input  logic                 M_MemWrite,
  input  logic                 M_Jal,
  input  logic                 M_ExtendLH,
  input  logic                 M_ExtendSH,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  input  logic [pc_size-1:0]   M_PCplus8,
  input  logic [4:0]           M_WR_out,
  input  logic                 DC_ready,
  input  logic [data_size-1:0] DC_rdata,
  output logic                 DC_req,
  output logic                 DC_we,
  output logic [addr_size-1:0] DC_addr,
  output logic [data_size-1:0] DC_wdata,
  output logic [3:0]           DC_be,
  output logic                 M_stall,
  output logic                 MW_RegWrite,
  output logic [4:0]           MW_WR_out,
  output logic [data_size-1:0] MW_Wdata
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_access,
  output logic [31:0]          perf_wait
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_dc_req;
  logic                   r_dc_we;
  logic [addr_size-1:0]   r_dc_addr;
  logic [data_size-1:0]   r_dc_wdata;
  logic [3:0]             r_dc_be;
  logic                   r_mw_regwrite;
  logic [4:0]             r_mw_wr_out;
  logic [data_size-1:0]   r_mw_wdata;

  logic                   w_mem_op;
  logic                   w_done;
  logic                   w_stall;
  logic                   w_hi_half;
  logic [3:0]             w_st_be;
  logic [data_size-1:0]   w_st_wdata;
  logic [15:0]            w_ld_half;
  logic [data_size-1:0]   w_ld_data;
  logic [data_size-1:0]   w_wb_data;
  logic                   w_unused;

  assign w_mem_op = M_MemtoReg | M_MemWrite;
  assign w_done   = (r_state == BUSY) & DC_ready;
  // EX/M holds the instruction until the completion edge, so M_* stay valid through BUSY.
  assign w_stall  = w_mem_op & ~w_done;

  // Big-endian: addr[1]=0 selects the upper halfword of the word.
  assign w_hi_half = ~M_ALU_result[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_st_be    = 4'b1111;
    w_st_wdata = M_Rt_data;
    if (M_MemWrite && M_ExtendSH) begin
      w_st_be    = w_hi_half ? 4'b1100 : 4'b0011;
      w_st_wdata = {2{M_Rt_data[15:0]}};
    end
  end

  always_comb begin
    w_ld_half = w_hi_half ? DC_rdata[31:16] : DC_rdata[15:0];
    w_ld_data = DC_rdata;
    if (M_ExtendLH) begin
      w_ld_data = {{(data_size-16){w_ld_half[15]}}, w_ld_half};
    end
  end

  always_comb begin
    w_wb_data = M_ALU_result;
    if (M_Jal) begin
      w_wb_data = {{(data_size-pc_size){1'b0}}, M_PCplus8};
    end else if (M_MemtoReg) begin
      w_wb_data = w_ld_data;
    end
  end

  // Address bits outside the cache word index are intentionally ignored.
  assign w_unused = ^{M_ALU_result[data_size-1:addr_size+2], M_ALU_result[0]};

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dc_req      <= 1'b0;
      r_dc_we       <= 1'b0;
      r_dc_addr     <= '0;
      r_dc_wdata    <= '0;
      r_dc_be       <= 4'b0000;
      r_mw_regwrite <= 1'b0;
      r_mw_wr_out   <= 5'd0;
      r_mw_wdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_state    <= BUSY;
            r_dc_req   <= 1'b1;
            r_dc_we    <= M_MemWrite;
            r_dc_addr  <= M_ALU_result[addr_size+1:2];
            r_dc_wdata <= w_st_wdata;
            r_dc_be    <= M_MemWrite ? w_st_be : 4'b1111;
          end
        end
        BUSY: begin
          if (DC_ready) begin
            r_state  <= IDLE;
            r_dc_req <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_stall) begin
        r_mw_regwrite <= 1'b0;
      end else begin
        r_mw_regwrite <= M_RegWrite;
        r_mw_wr_out   <= M_WR_out;
        r_mw_wdata    <= w_wb_data;
      end
    end
  end

`ifdef MEM_CTRL_PERF_EN
  logic [31:0] r_perf_access;
  logic [31:0] r_perf_wait;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_perf_access <= 32'd0;
      r_perf_wait   <= 32'd0;
    end else if (r_state == BUSY) begin
      if (DC_ready) r_perf_access <= r_perf_access + 32'd1;
      else          r_perf_wait   <= r_perf_wait + 32'd1;
    end
  end

  assign perf_access = r_perf_access;
  assign perf_wait   = r_perf_wait;
`endif

  assign DC_req      = r_dc_req;
  assign DC_we       = r_dc_we;
  assign DC_addr     = r_dc_addr;
  assign DC_wdata    = r_dc_wdata;
  assign DC_be       = r_dc_be;
  assign M_stall     = w_stall;
  assign MW_RegWrite = r_mw_regwrite;
  assign MW_WR_out   = r_mw_wr_out;
  assign MW_Wdata    = r_mw_wdata;

endmodule

// File: tb/tb_m_stage_mem_ctrl.sv
// Self-checking bench for m_stage_mem_ctrl: directed scenarios plus randomized instruction stream
// compared against a transaction-level model of the expected cache requests and write-back values.
module tb_m_stage_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal, M_ExtendLH, M_ExtendSH;
  logic [31:0] M_ALU_result, M_Rt_data;
  logic [17:0] M_PCplus8;
  logic [4:0]  M_WR_out;
  logic        DC_ready;
  logic [31:0] DC_rdata;
  logic        DC_req, DC_we;
  logic [15:0] DC_addr;
  logic [31:0] DC_wdata;
  logic [3:0]  DC_be;
  logic        M_stall;
  logic        MW_RegWrite;
  logic [4:0]  MW_WR_out;
  logic [31:0] MW_Wdata;
`ifdef MEM_CTRL_PERF_EN
  logic [31:0] perf_access, perf_wait;
`endif

  int checks   = 0;
  int failures = 0;

  // Model of the architecturally visible M/WB register and perf counts.
  logic        exp_rw;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  int unsigned exp_acc;
  int unsigned exp_wait;

  m_stage_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .M_MemtoReg(M_MemtoReg), .M_RegWrite(M_RegWrite), .M_MemWrite(M_MemWrite),
    .M_Jal(M_Jal), .M_ExtendLH(M_ExtendLH), .M_ExtendSH(M_ExtendSH),
    .M_ALU_result(M_ALU_result), .M_Rt_data(M_Rt_data), .M_PCplus8(M_PCplus8),
    .M_WR_out(M_WR_out), .DC_ready(DC_ready), .DC_rdata(DC_rdata),
    .DC_req(DC_req), .DC_we(DC_we), .DC_addr(DC_addr), .DC_wdata(DC_wdata),
    .DC_be(DC_be), .M_stall(M_stall), .MW_RegWrite(MW_RegWrite),
    .MW_WR_out(MW_WR_out), .MW_Wdata(MW_Wdata)
`ifdef MEM_CTRL_PERF_EN
    , .perf_access(perf_access), .perf_wait(perf_wait)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    M_MemtoReg = 0; M_RegWrite = 0; M_MemWrite = 0; M_Jal = 0;
    M_ExtendLH = 0; M_ExtendSH = 0; M_ALU_result = 0; M_Rt_data = 0;
    M_PCplus8 = 0; M_WR_out = 0; DC_ready = 0; DC_rdata = 0;
  endtask

  // Presents one instruction in M, plays the cache with 'waits' not-ready BUSY cycles,
  // and compares stall, request and M/WB against the model every cycle.
  task automatic run_instr(input string name, input logic mtr, input logic rw, input logic mw,
                           input logic jal, input logic elh, input logic esh,
                           input logic [31:0] alu, input logic [31:0] rt, input logic [17:0] pc8,
                           input logic [4:0] wr, input int waits, input logic [31:0] rdata);
    logic        mem_op;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_wb, e_load;
    logic [15:0] half;
    logic        e_stall, last;
    int          ncyc;
    mem_op  = mtr | mw;
    e_be    = (mw && esh) ? (alu[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    e_wdata = (mw && esh) ? {rt[15:0], rt[15:0]} : rt;
    half    = alu[1] ? rdata[15:0] : rdata[31:16];
    e_load  = elh ? (half[15] ? {16'hFFFF, half} : {16'h0000, half}) : rdata;
    e_wb    = jal ? {14'd0, pc8} : (mtr ? e_load : alu);
    ncyc    = mem_op ? waits + 2 : 1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      M_MemtoReg = mtr; M_RegWrite = rw; M_MemWrite = mw; M_Jal = jal;
      M_ExtendLH = elh; M_ExtendSH = esh; M_ALU_result = alu; M_Rt_data = rt;
      M_PCplus8 = pc8; M_WR_out = wr;
      last = (c == ncyc - 1);
      if (mem_op && last) begin
        DC_ready = 1'b1; DC_rdata = rdata;
      end else begin
        DC_ready = (c == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        DC_rdata = $urandom;
      end
      #1;
      e_stall = mem_op && !last;
      checks++;
      if (M_stall !== e_stall) begin
        failures++;
        $display("FAIL %s stall c=%0d: got %b want %b", name, c, M_stall, e_stall);
      end
      @(negedge clk); #1;
      if (!last) begin
        checks++;
        if (DC_req !== 1'b1 || DC_we !== mw || DC_addr !== alu[17:2] || DC_be !== e_be) begin
          failures++;
          $display("FAIL %s req c=%0d: got req=%b we=%b addr=%h be=%b want 1 %b %h %b",
                   name, c, DC_req, DC_we, DC_addr, DC_be, mw, alu[17:2], e_be);
        end
        if (mw) begin
          checks++;
          if (DC_wdata !== e_wdata) begin
            failures++;
            $display("FAIL %s wdata: got %h want %h", name, DC_wdata, e_wdata);
          end
        end
        checks++;
        if (MW_RegWrite !== 1'b0 || MW_WR_out !== exp_wr || MW_Wdata !== exp_wd) begin
          failures++;
          $display("FAIL %s bubble c=%0d: got rw=%b wr=%0d wd=%h want 0 %0d %h",
                   name, c, MW_RegWrite, MW_WR_out, MW_Wdata, exp_wr, exp_wd);
        end
      end else begin
        exp_rw = rw; exp_wr = wr; exp_wd = e_wb;
        if (mem_op) begin
          exp_acc++;
          exp_wait += waits;
        end
        checks++;
        if (DC_req !== 1'b0) begin
          failures++;
          $display("FAIL %s req_drop: got %b want 0", name, DC_req);
        end
        checks++;
        if (MW_RegWrite !== exp_rw || MW_WR_out !== exp_wr || MW_Wdata !== exp_wd) begin
          failures++;
          $display("FAIL %s writeback: got rw=%b wr=%0d wd=%h want %b %0d %h",
                   name, MW_RegWrite, MW_WR_out, MW_Wdata, exp_rw, exp_wr, exp_wd);
        end
      end
    end
`ifdef MEM_CTRL_PERF_EN
    checks++;
    if (perf_access !== exp_acc || perf_wait !== exp_wait) begin
      failures++;
      $display("FAIL %s perf: got acc=%0d wait=%0d want %0d %0d",
               name, perf_access, perf_wait, exp_acc, exp_wait);
    end
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({DC_req, DC_we, DC_addr, DC_wdata, DC_be, M_stall, MW_RegWrite, MW_WR_out, MW_Wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h be=%b stall=%b rw=%b wr=%0d mwd=%h want all 0",
               DC_req, DC_we, DC_addr, DC_wdata, DC_be, M_stall, MW_RegWrite, MW_WR_out, MW_Wdata);
    end
    exp_rw = 0; exp_wr = 0; exp_wd = 0; exp_acc = 0; exp_wait = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("alu_after_reset", 0, 1, 0, 0, 0, 0, 32'h1234, 32'h0, 18'h0, 5'd5, 0, 32'h0);
  endtask

  task automatic test_load_word();
    run_instr("load_word_0wait", 1, 1, 0, 0, 0, 0, 32'h40, 32'h0, 18'h0, 5'd7, 0, 32'hDEADBEEF);
  endtask

  task automatic test_extend_lh();
    run_instr("lh_hi_3wait", 1, 1, 0, 0, 1, 0, 32'h100, 32'h0, 18'h0, 5'd9, 3, 32'h8001_7FFF);
    run_instr("lh_lo_3wait", 1, 1, 0, 0, 1, 0, 32'h102, 32'h0, 18'h0, 5'd10, 3, 32'h8001_7FFF);
  endtask

  task automatic test_store_half();
    run_instr("sh_lo", 0, 0, 1, 0, 0, 1, 32'h06, 32'h0000_ABCD, 18'h0, 5'd3, 2, 32'h0);
    run_instr("sh_hi", 0, 0, 1, 0, 0, 1, 32'h04, 32'h1234_5678, 18'h0, 5'd3, 0, 32'h0);
    run_instr("sw", 0, 0, 1, 0, 0, 0, 32'h0F, 32'hCAFE_BABE, 18'h0, 5'd3, 1, 32'h0);
  endtask

  task automatic test_jal();
    run_instr("jal", 0, 1, 0, 1, 0, 0, 32'h5555, 32'h0, 18'h00208, 5'd31, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_ld0", 1, 1, 0, 0, 0, 0, 32'h200, 32'h0, 18'h0, 5'd1, 0, 32'h1111_2222);
    run_instr("b2b_ld1", 1, 1, 0, 0, 0, 0, 32'h204, 32'h0, 18'h0, 5'd2, 0, 32'h3333_4444);
    run_instr("b2b_sw", 0, 0, 1, 0, 0, 0, 32'h208, 32'h5555_6666, 18'h0, 5'd4, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] alu, rt, rdata;
      logic [17:0] pc8;
      logic [4:0]  wr;
      int          waits;
      kind  = $urandom_range(0, 5);
      alu   = $urandom; rt = $urandom; rdata = $urandom;
      pc8   = 18'($urandom); wr = 5'($urandom);
      waits = $urandom_range(0, 4);
      case (kind)
        0: run_instr("rnd_alu", 0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, alu, rt, pc8, wr, 0, rdata);
        1: run_instr("rnd_lw",  1, 1, 0, 0, 0, 0, alu, rt, pc8, wr, waits, rdata);
        2: run_instr("rnd_lh",  1, 1, 0, 0, 1, 0, alu, rt, pc8, wr, waits, rdata);
        3: run_instr("rnd_sw",  0, 0, 1, 0, 0, 0, alu, rt, pc8, wr, waits, rdata);
        4: run_instr("rnd_sh",  0, 0, 1, 0, 0, 1, alu, rt, pc8, wr, waits, rdata);
        default: run_instr("rnd_jal", 0, 1, 0, 1, 0, 0, alu, rt, pc8, wr, 0, rdata);
      endcase
    end
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    M_MemtoReg = 1; M_RegWrite = 1; M_ALU_result = 32'h80; M_WR_out = 5'd12;
    DC_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (DC_req !== 1'b1) begin
      failures++;
      $display("FAIL midbusy_req_before_rst: got %b want 1", DC_req);
    end
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (DC_req !== 1'b0 || MW_RegWrite !== 1'b0 || MW_Wdata !== 32'h0) begin
      failures++;
      $display("FAIL midbusy_reset: got req=%b rw=%b wd=%h want 0 0 0", DC_req, MW_RegWrite, MW_Wdata);
    end
    exp_rw = 0; exp_wr = 0; exp_wd = 0; exp_acc = 0; exp_wait = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    DC_ready = 1'b1; DC_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (M_stall !== 1'b0) begin
      failures++;
      $display("FAIL late_ready_stall: got %b want 0", M_stall);
    end
    @(negedge clk); #1;
    checks++;
    if (DC_req !== 1'b0 || MW_RegWrite !== 1'b0 || MW_Wdata !== 32'h0) begin
      failures++;
      $display("FAIL late_ready: got req=%b rw=%b wd=%h want 0 0 0", DC_req, MW_RegWrite, MW_Wdata);
    end
`ifdef MEM_CTRL_PERF_EN
    checks++;
    if (perf_access !== 32'd0) begin
      failures++;
      $display("FAIL late_ready_perf: got %0d want 0", perf_access);
    end
`endif
    DC_ready = 1'b0;
    run_instr("load_after_reset", 1, 1, 0, 0, 0, 0, 32'h84, 32'h0, 18'h0, 5'd13, 1, 32'h0BAD_F00D);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_word();
    test_extend_lh();
    test_store_half();
    test_jal();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
